// File: rtl/matmul_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_result_drain_if
// Description : Bus bundle between the result drain sequencer, the synchronous
//               result RAM read port and the output writer handshake.
//               Signals:
//                 rd_en, rd_row, rd_col  - RAM read strobe and row/col address
//                 rd_data                - RAM word, valid the cycle after rd_en
//                 value, value_stb       - element offered to the writer
//                 value_ack              - writer accepts the offered element
//                 row, col               - indices of the offered element
//               master : drain side, slave : RAM + writer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_result_drain_if #(
   parameter int N  = 8,
   parameter int DW = 32
);
   localparam int IW = $clog2(N);

   logic          rd_en;
   logic [IW-1:0] rd_row;
   logic [IW-1:0] rd_col;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] value;
   logic          value_stb;
   logic          value_ack;
   logic [IW-1:0] row;
   logic [IW-1:0] col;

   modport master (
      output rd_en, rd_row, rd_col,
      input  rd_data,
      output value, value_stb, row, col,
      input  value_ack
   );

   modport slave (
      input  rd_en, rd_row, rd_col,
      output rd_data,
      input  value, value_stb, row, col,
      output value_ack
   );
endinterface
`default_nettype wire

// File: rtl/matmul_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : matmul_result_drain
// Description : Drains the N x N result matrix from the synchronous result RAM
//               in row-major order and offers each element to the writer over
//               a value_stb/value_ack handshake, then pulses done.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               i_start  - begin a drain (honoured only in IDLE)
//               i_abort  - synchronous cancel of a drain in progress
//               o_busy   - high in every state except IDLE
//               o_done   - one-cycle pulse after the last element is accepted
//               bus      - RAM read port and writer handshake (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_result_drain #(
   parameter int N  = 8,
   parameter int DW = 32
) (
   input  wire                       clk,
   input  wire                       rst_n,
   input  wire                       i_start,
   input  wire                       i_abort,
   output logic                      o_busy,
   output logic                      o_done,
   matmul_result_drain_if.master     bus
);
   localparam int            IW         = $clog2(N);
   localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_OFFER   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_rd_en;
   logic          w_rd_en_nxt;
   logic          r_stb;
   logic          w_stb_nxt;
   logic [DW-1:0] r_value;
   logic [DW-1:0] w_value_nxt;
   logic [IW-1:0] r_row;
   logic [IW-1:0] w_row_nxt;
   logic [IW-1:0] r_col;
   logic [IW-1:0] w_col_nxt;
   logic          w_last;

   assign w_last = (r_row == c_LAST_IDX) && (r_col == c_LAST_IDX);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en_nxt = 1'b0;          // read strobe lasts exactly one cycle
      w_stb_nxt   = r_stb;
      w_value_nxt = r_value;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;

      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               w_state_nxt = S_FETCH;
               w_rd_en_nxt = 1'b1;
               w_row_nxt   = '0;
               w_col_nxt   = '0;
            end
         end

         S_FETCH: begin
            w_state_nxt = i_abort ? S_IDLE : S_CAPTURE;
         end

         S_CAPTURE: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
               w_stb_nxt   = 1'b0;
            end else begin
               w_state_nxt = S_OFFER;
               w_value_nxt = bus.rd_data;
               w_stb_nxt   = 1'b1;
            end
         end

         S_OFFER: begin
            // Abort takes priority: a simultaneous ack is not a delivery.
            if (i_abort) begin
               w_state_nxt = S_IDLE;
               w_stb_nxt   = 1'b0;
            end else if (bus.value_ack) begin
               w_stb_nxt = 1'b0;
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_FETCH;
                  w_rd_en_nxt = 1'b1;
                  if (r_col == c_LAST_IDX) begin
                     w_col_nxt = '0;
                     w_row_nxt = r_row + IW'(1);
                  end else begin
                     w_col_nxt = r_col + IW'(1);
                  end
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_stb_nxt   = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en <= 1'b0;
         r_stb   <= 1'b0;
         r_value <= '0;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         r_rd_en <= w_rd_en_nxt;
         r_stb   <= w_stb_nxt;
         r_value <= w_value_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
      end
   end

   // The RAM address is always loaded together with the element indices, so
   // one register pair serves both the read address and the offered indices.
   assign bus.rd_en     = r_rd_en;
   assign bus.rd_row    = r_row;
   assign bus.rd_col    = r_col;
   assign bus.value     = r_value;
   assign bus.value_stb = r_stb;
   assign bus.row       = r_row;
   assign bus.col       = r_col;

   assign o_busy = (r_state != S_IDLE);
   assign o_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_matmul_result_drain.sv
`timescale 1ns/1ps
module tb_matmul_result_drain;

   typedef struct {
      int          r;
      int          c;
      logic [31:0] v;
   } elem_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start4, abort4, busy4, done4;
   logic start2, abort2, busy2, done2;

   matmul_result_drain_if #(.N(4), .DW(32)) bus4 ();
   matmul_result_drain_if #(.N(2), .DW(32)) bus2 ();

   matmul_result_drain #(.N(4), .DW(32)) u_dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (start4),
      .i_abort (abort4),
      .o_busy  (busy4),
      .o_done  (done4),
      .bus     (bus4)
   );

   matmul_result_drain #(.N(2), .DW(32)) u_dut2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (start2),
      .i_abort (abort2),
      .o_busy  (busy2),
      .o_done  (done2),
      .bus     (bus2)
   );

   // Behavioural RAM contents and scoreboards
   logic [31:0] mem4 [4][4];
   logic [31:0] mem2 [2][2];
   elem_t       exp4[$];
   elem_t       exp2[$];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int ack_mode = 0;   // 0: always ack, 1: random ack, 2: stall element (1,2)
   int hold_cnt = 0;
   int rd_cnt4 = 0, done_cnt4 = 0, stb_cycles4 = 0;
   int rd_cnt2 = 0, done_cnt2 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous result RAMs: data valid the cycle after rd_en
   always @(posedge clk) if (bus4.rd_en) bus4.rd_data <= mem4[bus4.rd_row][bus4.rd_col];
   always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= mem2[bus2.rd_row][bus2.rd_col];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Writer ack generator for the N=4 instance
   initial begin
      bus4.value_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ack_mode)
            0: bus4.value_ack = 1'b1;
            1: bus4.value_ack = ($urandom_range(0, 2) != 0);
            default: begin
               if (bus4.value_stb && bus4.row == 2'd1 && bus4.col == 2'd2 && hold_cnt < 5) begin
                  bus4.value_ack = 1'b0;
                  hold_cnt++;
               end else begin
                  bus4.value_ack = 1'b1;
               end
            end
         endcase
      end
   end

   // Monitor N=4: every offered cycle must show the scoreboard head
   always @(negedge clk) begin
      if (!rst_n) begin
         stb_cycles4 = 0;
      end else begin
         if (bus4.rd_en) rd_cnt4++;
         if (done4) done_cnt4++;
         if (bus4.value_stb) begin
            stb_cycles4++;
            if (exp4.size() == 0) begin
               check("n4_unexpected_stb", 64'd1, 64'd0);
            end else begin
               check("n4_elem", {8'(bus4.row), 8'(bus4.col), bus4.value},
                                {8'(exp4[0].r), 8'(exp4[0].c), exp4[0].v});
               if (bus4.value_ack && !abort4) begin
                  if (ack_mode == 0)
                     check("n4_offer_len", 64'(stb_cycles4), 64'd1);
                  else if (ack_mode == 2 && exp4[0].r == 1 && exp4[0].c == 2)
                     check("n4_hold_len", 64'(stb_cycles4), 64'd6);
                  void'(exp4.pop_front());
                  stb_cycles4 = 0;
               end
            end
            if (abort4) stb_cycles4 = 0;
         end
      end
   end

   // Monitor N=2 (ack tied high)
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus2.rd_en) rd_cnt2++;
         if (done2) done_cnt2++;
         if (bus2.value_stb) begin
            if (exp2.size() == 0) begin
               check("n2_unexpected_stb", 64'd1, 64'd0);
            end else begin
               check("n2_elem", {8'(bus2.row), 8'(bus2.col), bus2.value},
                                {8'(exp2[0].r), 8'(exp2[0].c), exp2[0].v});
               if (bus2.value_ack) void'(exp2.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic fill_mem4(input bit rnd);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mem4[r][c] = rnd ? 32'($urandom) : 32'(16 * r + c);
   endtask

   task automatic push_all4();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            exp4.push_back('{r, c, mem4[r][c]});
   endtask

   task automatic pulse4(output int t0);
      @(posedge clk); #1 start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
      t0 = cyc;   // cycle index of the edge that sampled start
   endtask

   // Full drain of the 4x4 instance; timing is only exact with ack tied high
   task automatic drain4(input int mode);
      int t0, first, done_at, d0;
      bit finished;
      ack_mode = mode;
      hold_cnt = 0;
      push_all4();
      rd_cnt4  = 0;
      d0       = done_cnt4;
      first    = -1;
      done_at  = -1;
      finished = 1'b0;
      pulse4(t0);
      for (int k = 0; k < 3000 && !finished; k++) begin
         @(negedge clk);
         if (bus4.value_stb && first < 0) first = cyc - t0;
         if (done4) done_at = cyc - t0;
         if (!busy4) finished = 1'b1;
      end
      check("n4_drain_finished", 64'(finished), 64'd1);
      check("n4_queue_empty", 64'(exp4.size()), 64'd0);
      check("n4_rd_en_count", 64'(rd_cnt4), 64'd16);
      check("n4_done_count", 64'(done_cnt4 - d0), 64'd1);
      if (mode == 0) begin
         check("n4_first_stb_latency", 64'(first), 64'd2);
         check("n4_done_latency", 64'(done_at), 64'(3 * 16));
         check("n4_busy_length", 64'(cyc - t0), 64'(3 * 16 + 1));
      end
   endtask

   // Wait (bounded) until element (r,c) is offered, sampled 2ns after an edge
   task automatic wait_offer4(input int r, input int c, output bit found);
      found = 1'b0;
      for (int k = 0; k < 500 && !found; k++) begin
         @(posedge clk); #2;
         if (bus4.value_stb && bus4.row == 2'(r) && bus4.col == 2'(c)) found = 1'b1;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int  t0, d0;
      bit  found, finished;

      rst_n  = 1'b0;
      start4 = 1'b0;
      abort4 = 1'b0;
      start2 = 1'b0;
      abort2 = 1'b0;
      bus2.value_ack = 1'b1;
      fill_mem4(1'b0);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            mem2[r][c] = 32'(16 * r + c);

      repeat (3) @(posedge clk);
      #1;
      check("reset_state_n4", {busy4, done4, bus4.rd_en, bus4.value_stb, bus4.row, bus4.col, bus4.value}, 64'd0);
      check("reset_state_n2", {busy2, done2, bus2.rd_en, bus2.value_stb, bus2.row, bus2.col, bus2.value}, 64'd0);
      #2 rst_n = 1'b1;
      repeat (2) tick();

      // Plain row-major drain with zero-wait ack
      drain4(0);

      // Writer stalls element (1,2) for 5 cycles
      drain4(2);

      // Abort in OFFER of (2,0) together with ack
      ack_mode = 0;
      push_all4();
      d0 = done_cnt4;
      pulse4(t0);
      wait_offer4(2, 0, found);
      check("abort_reach_2_0", 64'(found), 64'd1);
      abort4 = 1'b1;
      @(posedge clk); #1 abort4 = 1'b0;
      check("abort_busy", 64'(busy4), 64'd0);
      check("abort_stb", 64'(bus4.value_stb), 64'd0);
      check("abort_rd_en", 64'(bus4.rd_en), 64'd0);
      exp4.delete();
      repeat (5) tick();
      check("abort_no_done", 64'(done_cnt4 - d0), 64'd0);
      check("abort_stays_idle", {busy4, bus4.value_stb}, 64'd0);
      drain4(0);

      // Start pulse in the middle of a drain is ignored
      fill_mem4(1'b1);
      fork
         drain4(1);
         begin
            repeat (25) @(posedge clk);
            #1 start4 = 1'b1;
            @(posedge clk); #1 start4 = 1'b0;
         end
      join
      repeat (4) tick();
      check("midstart_no_restart", 64'(busy4), 64'd0);

      // Asynchronous reset during CAPTURE of element (0,3)
      fill_mem4(1'b0);
      ack_mode = 0;
      push_all4();
      pulse4(t0);
      wait_offer4(0, 2, found);
      check("rst_reach_0_2", 64'(found), 64'd1);
      @(posedge clk);   // handshake -> FETCH (0,3)
      @(posedge clk);   // -> CAPTURE
      #3 rst_n = 1'b0;
      #1;
      check("rst_async_ctrl", {busy4, done4, bus4.rd_en, bus4.value_stb}, 64'd0);
      check("rst_async_idx", {bus4.row, bus4.col, bus4.rd_row, bus4.rd_col}, 64'd0);
      check("rst_async_value", 64'(bus4.value), 64'd0);
      exp4.delete();
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (6) tick();
      check("rst_waits_for_start", {busy4, bus4.value_stb, bus4.rd_en}, 64'd0);
      fill_mem4(1'b1);
      drain4(1);

      // N=2 boundary: wrap (0,1)->(1,0) and last element (1,1)
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            exp2.push_back('{r, c, mem2[r][c]});
      rd_cnt2  = 0;
      d0       = done_cnt2;
      finished = 1'b0;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      t0 = cyc;
      for (int k = 0; k < 500 && !finished; k++) begin
         @(negedge clk);
         if (!busy2) finished = 1'b1;
      end
      check("n2_drain_finished", 64'(finished), 64'd1);
      check("n2_queue_empty", 64'(exp2.size()), 64'd0);
      check("n2_rd_en_count", 64'(rd_cnt2), 64'd4);
      check("n2_done_count", 64'(done_cnt2 - d0), 64'd1);
      check("n2_busy_length", 64'(cyc - t0), 64'(3 * 4 + 1));

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
